// File: rtl/mem_access.sv
// Memory-access pipeline stage: issues data-bus loads/stores for the EX/MEM
// instruction, stalls EX/MEM while in flight, and registers the result to MEM/WB.
module mem_access (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [63:0] in_pc,
    input  logic        in_mem_read,
    input  logic        in_mem_write,
    input  logic [2:0]  in_funct3,
    input  logic [63:0] in_addr,
    input  logic [63:0] in_store_data,
    input  logic [4:0]  in_rd,
    input  logic        in_reg_write,
    output logic        stall_out,
    output logic        dreq_valid,
    output logic [63:0] dreq_addr,
    output logic [2:0]  dreq_size,
    output logic [7:0]  dreq_strobe,
    output logic [63:0] dreq_data,
    input  logic        dresp_addr_ok,
    input  logic        dresp_data_ok,
    input  logic [63:0] dresp_data,
    output logic        out_valid,
    output logic [63:0] out_pc,
    output logic [4:0]  out_rd,
    output logic        out_reg_write,
    output logic [63:0] out_wb_value,
    output logic        out_misalign
);

    localparam int unsigned XLEN = 64;

    typedef enum logic {
        S_IDLE      = 1'b0,
        S_WAIT_DATA = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_mem_op;
    logic              w_misalign;
    logic              w_complete;
    logic [1:0]        w_size;
    logic [2:0]        w_k;
    logic [2:0]        w_low_mask;
    logic [7:0]        w_lane_mask;
    logic [XLEN-1:0]   w_raw;
    logic [XLEN-1:0]   w_ld_ext;

    // Access decode, bus request, handshake tracking and load extension
    always_comb begin
        w_state_nxt = r_state;
        w_size      = in_funct3[1:0];
        w_k         = in_addr[2:0];
        w_low_mask  = 3'b000;
        w_lane_mask = 8'h01;
        w_ld_ext    = '0;

        case (w_size)
            2'd0:    begin w_low_mask = 3'b000; w_lane_mask = 8'h01; end
            2'd1:    begin w_low_mask = 3'b001; w_lane_mask = 8'h03; end
            2'd2:    begin w_low_mask = 3'b011; w_lane_mask = 8'h0F; end
            default: begin w_low_mask = 3'b111; w_lane_mask = 8'hFF; end
        endcase

        w_mem_op   = in_valid & (in_mem_read | in_mem_write);
        w_misalign = w_mem_op & ((w_k & w_low_mask) != 3'b000);
        dreq_valid = w_mem_op & ~w_misalign & (r_state == S_IDLE);
        w_complete = dresp_data_ok & ((r_state == S_WAIT_DATA) | (dreq_valid & dresp_addr_ok));
        stall_out  = w_mem_op & ~w_misalign & ~w_complete;

        case (r_state)
            S_IDLE:      if (dreq_valid & dresp_addr_ok & ~dresp_data_ok) w_state_nxt = S_WAIT_DATA;
            S_WAIT_DATA: if (dresp_data_ok) w_state_nxt = S_IDLE;
            default:     w_state_nxt = S_IDLE;
        endcase

        dreq_addr   = in_addr;
        dreq_size   = {1'b0, w_size};
        dreq_strobe = in_mem_write ? (w_lane_mask << w_k) : 8'h00;
        dreq_data   = in_store_data << {w_k, 3'b000};

        w_raw = dresp_data >> {w_k, 3'b000};
        case (in_funct3)
            3'd0:    w_ld_ext = {{56{w_raw[7]}},  w_raw[7:0]};
            3'd1:    w_ld_ext = {{48{w_raw[15]}}, w_raw[15:0]};
            3'd2:    w_ld_ext = {{32{w_raw[31]}}, w_raw[31:0]};
            3'd3:    w_ld_ext = w_raw;
            3'd4:    w_ld_ext = {56'd0, w_raw[7:0]};
            3'd5:    w_ld_ext = {48'd0, w_raw[15:0]};
            3'd6:    w_ld_ext = {32'd0, w_raw[31:0]};
            default: w_ld_ext = '0;
        endcase
    end

    // State register and MEM/WB output register; a stall emits a bubble
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            out_valid     <= 1'b0;
            out_pc        <= '0;
            out_rd        <= '0;
            out_reg_write <= 1'b0;
            out_wb_value  <= '0;
            out_misalign  <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            out_valid     <= in_valid & ~stall_out;
            out_pc        <= in_pc;
            out_rd        <= in_rd;
            out_reg_write <= in_reg_write & ~w_misalign;
            out_misalign  <= w_misalign;
            out_wb_value  <= (in_mem_read & w_mem_op & w_complete) ? w_ld_ext : in_addr;
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: directed scenarios then random instructions with random
// bus handshake latencies, checked against a transaction-level reference model.
module tb_mem_access;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [63:0] in_pc;
    logic        in_mem_read;
    logic        in_mem_write;
    logic [2:0]  in_funct3;
    logic [63:0] in_addr;
    logic [63:0] in_store_data;
    logic [4:0]  in_rd;
    logic        in_reg_write;
    logic        stall_out;
    logic        dreq_valid;
    logic [63:0] dreq_addr;
    logic [2:0]  dreq_size;
    logic [7:0]  dreq_strobe;
    logic [63:0] dreq_data;
    logic        dresp_addr_ok;
    logic        dresp_data_ok;
    logic [63:0] dresp_data;
    logic        out_valid;
    logic [63:0] out_pc;
    logic [4:0]  out_rd;
    logic        out_reg_write;
    logic [63:0] out_wb_value;
    logic        out_misalign;

    int total = 0;
    int bad   = 0;

    mem_access dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_pc(in_pc),
        .in_mem_read(in_mem_read), .in_mem_write(in_mem_write), .in_funct3(in_funct3),
        .in_addr(in_addr), .in_store_data(in_store_data), .in_rd(in_rd),
        .in_reg_write(in_reg_write), .stall_out(stall_out), .dreq_valid(dreq_valid),
        .dreq_addr(dreq_addr), .dreq_size(dreq_size), .dreq_strobe(dreq_strobe),
        .dreq_data(dreq_data), .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok),
        .dresp_data(dresp_data), .out_valid(out_valid), .out_pc(out_pc), .out_rd(out_rd),
        .out_reg_write(out_reg_write), .out_wb_value(out_wb_value), .out_misalign(out_misalign)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int nbytes(input logic [2:0] f3);
        return 1 << int'(f3[1:0]);
    endfunction

    function automatic logic [63:0] ld_model(input logic [2:0] f3, input logic [63:0] addr,
                                             input logic [63:0] bus);
        int          nb   = nbytes(f3);
        int          k    = int'(addr[2:0]);
        logic [63:0] mask = (nb == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * nb)) - 64'd1);
        logic [63:0] v    = (bus >> (8 * k)) & mask;
        if (f3 < 3'd4 && nb < 8 && v[8 * nb - 1]) v = v | ~mask;
        return v;
    endfunction

    // Drives one EX/MEM instruction (inputs already set) through to its completing edge.
    // a = cycle of addr_ok, d = cycle of data_ok (d >= a), for issued accesses only.
    task automatic run_op(input string name, input int a, input int d);
        logic        mem_op = in_valid & (in_mem_read | in_mem_write);
        int          nb     = nbytes(in_funct3);
        logic        mis    = mem_op && ((int'(in_addr[2:0]) % nb) != 0);
        logic        issued = mem_op && !mis;
        int          k      = int'(in_addr[2:0]);
        int          strb   = in_mem_write ? ((((1 << nb) - 1) << k) & 255) : 0;
        logic [63:0] exp_wb;
        if (!issued) begin a = 0; d = 0; end
        exp_wb = (issued && in_mem_read) ? ld_model(in_funct3, in_addr, dresp_data) : in_addr;
        for (int c = 0; c <= d; c++) begin
            dresp_addr_ok = issued ? (c == a) : 1'($urandom_range(0, 1));
            dresp_data_ok = issued ? (c == d) : 1'($urandom_range(0, 1));
            @(negedge clk);
            chk({name, ".stall"}, 64'(stall_out), 64'(issued && c < d));
            chk({name, ".dreq_valid"}, 64'(dreq_valid), 64'(issued && c <= a));
            if (issued && c == 0) begin
                chk({name, ".dreq_addr"}, dreq_addr, in_addr);
                chk({name, ".dreq_size"}, 64'(dreq_size), 64'(in_funct3[1:0]));
                chk({name, ".dreq_strobe"}, 64'(dreq_strobe), 64'(strb));
                if (in_mem_write)
                    chk({name, ".dreq_data"}, dreq_data, in_store_data << (8 * k));
            end
            @(posedge clk); #1;
            if (c < d) chk({name, ".bubble"}, 64'(out_valid), 64'd0);
        end
        dresp_addr_ok = 1'b0;
        dresp_data_ok = 1'b0;
        chk({name, ".out_valid"}, 64'(out_valid), 64'(in_valid));
        chk({name, ".out_misalign"}, 64'(out_misalign), 64'(mis));
        chk({name, ".out_reg_write"}, 64'(out_reg_write), 64'(in_reg_write && !mis));
        chk({name, ".out_pc"}, out_pc, in_pc);
        chk({name, ".out_rd"}, 64'(out_rd), 64'(in_rd));
        if (!mis) chk({name, ".out_wb"}, out_wb_value, exp_wb);
    endtask

    task automatic set_op(input logic v, input logic rd_op, input logic wr_op, input logic [2:0] f3,
                          input logic [63:0] addr, input logic [63:0] sdata, input logic [4:0] rd);
        in_valid      = v;
        in_pc         = {$urandom, $urandom};
        in_mem_read   = rd_op;
        in_mem_write  = wr_op;
        in_funct3     = f3;
        in_addr       = addr;
        in_store_data = sdata;
        in_rd         = rd;
        in_reg_write  = !wr_op;
    endtask

    initial begin
        reset = 1'b0;
        dresp_addr_ok = 1'b0;
        dresp_data_ok = 1'b0;
        dresp_data = '0;
        set_op(1'b0, 1'b0, 1'b0, 3'd0, 64'd0, 64'd0, 5'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst.out_valid", 64'(out_valid), 64'd0);
        chk("rst.out_wb", out_wb_value, 64'd0);
        chk("rst.out_pc", out_pc, 64'd0);
        reset = 1'b1;

        set_op(1'b1, 1'b0, 1'b0, 3'd0, 64'h1234, 64'd0, 5'd5);
        run_op("alu", 0, 0);

        dresp_data = 64'h0000_0000_8000_0000;
        set_op(1'b1, 1'b1, 1'b0, 3'd0, 64'h1003, 64'd0, 5'd7);
        run_op("lb", 0, 0);
        chk("lb.value", out_wb_value, 64'hFFFF_FFFF_FFFF_FF80);
        set_op(1'b1, 1'b1, 1'b0, 3'd4, 64'h1003, 64'd0, 5'd7);
        run_op("lbu", 0, 0);
        chk("lbu.value", out_wb_value, 64'h80);

        set_op(1'b1, 1'b0, 1'b1, 3'd1, 64'h1006, 64'hBEEF, 5'd0);
        @(negedge clk);
        chk("sh.strobe", 64'(dreq_strobe), 64'hC0);
        chk("sh.data", dreq_data, 64'hBEEF_0000_0000_0000);
        chk("sh.size", 64'(dreq_size), 64'd1);
        @(posedge clk); #1;
        run_op("sh", 0, 0);

        dresp_data = 64'h0123_4567_89AB_CDEF;
        set_op(1'b1, 1'b1, 1'b0, 3'd3, 64'h2000, 64'd0, 5'd9);
        run_op("ld_slow", 2, 5);

        set_op(1'b1, 1'b1, 1'b0, 3'd2, 64'h2002, 64'd0, 5'd3);
        run_op("lw_mis", 0, 0);
        chk("lw_mis.regwr", 64'(out_reg_write), 64'd0);

        // Reset while an access waits for data
        set_op(1'b1, 1'b1, 1'b0, 3'd3, 64'h3000, 64'd0, 5'd11);
        dresp_addr_ok = 1'b1;
        @(negedge clk);
        chk("abort.dreq_c0", 64'(dreq_valid), 64'd1);
        @(posedge clk); #1;
        dresp_addr_ok = 1'b0;
        @(negedge clk);
        chk("abort.dreq_wait", 64'(dreq_valid), 64'd0);
        chk("abort.stall_wait", 64'(stall_out), 64'd1);
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        chk("abort.out_valid", 64'(out_valid), 64'd0);
        chk("abort.out_pc", out_pc, 64'd0);
        chk("abort.out_rd", 64'(out_rd), 64'd0);
        chk("abort.out_regwr", 64'(out_reg_write), 64'd0);
        chk("abort.out_wb", out_wb_value, 64'd0);
        chk("abort.out_mis", 64'(out_misalign), 64'd0);
        run_op("abort.retry", 1, 2);

        for (int i = 0; i < 60; i++) begin
            int          kind  = $urandom_range(0, 2);
            logic [2:0]  f3    = (kind == 1) ? 3'($urandom_range(0, 6)) : 3'($urandom_range(0, 3));
            logic [63:0] addr  = {$urandom, $urandom};
            int          a     = $urandom_range(0, 3);
            int          d     = a + $urandom_range(0, 3);
            if ($urandom_range(0, 3) != 0) addr = addr & ~((64'd1 << f3[1:0]) - 64'd1);
            dresp_data = {$urandom, $urandom};
            set_op(1'($urandom_range(0, 9) != 0), 1'(kind == 1), 1'(kind == 2), f3, addr,
                   {$urandom, $urandom}, 5'($urandom));
            run_op($sformatf("rnd%0d", i), a, d);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_access.md
# mem_access

Memory-access stage that consumes the instruction held in the EX/MEM pipeline register and drives the data bus. It issues loads and stores, waits for the bus handshake, and stalls EX/MEM while an access is in flight. It aligns and extends load data, then registers the result toward MEM/WB. It is the reading end of the EX/MEM interface; the stall it produces is the only back-pressure EX/MEM receives from the memory side.

## Interface
No parameters. XLEN is fixed at 64.
- clk  in  1  clock.
- reset  in  1  synchronous, active-low; reset==0 at a rising edge resets the block.
- in_valid  in  1  EX/MEM holds a valid instruction.
- in_pc  in  64  PC of the instruction.
- in_mem_read / in_mem_write  in  1 / 1  load / store; never both set.
- in_funct3  in  3  access size and signedness (RISC-V load/store funct3).
- in_addr  in  64  effective address; for non-memory ops, the ALU result to write back.
- in_store_data  in  64  store value, right-aligned.
- in_rd  in  5  destination register.
- in_reg_write  in  1  register write enable.
- stall_out  out  1  combinational; holds EX/MEM.
- dreq_valid  out  1  data-bus request.
- dreq_addr  out  64  equals in_addr.
- dreq_size  out  3  0/1/2/3 = 1/2/4/8 bytes.
- dreq_strobe  out  8  byte enables; 0 for loads.
- dreq_data  out  64  store data, lane-shifted.
- dresp_addr_ok  in  1  request accepted.
- dresp_data_ok  in  1  data returned / write done.
- dresp_data  in  64  aligned doubleword containing the addressed bytes.
- out_valid, out_pc, out_rd, out_reg_write, out_wb_value, out_misalign  out  1/64/5/1/64/1  registered result toward MEM/WB.

## Operation
- mem_op = in_valid & (in_mem_read | in_mem_write).
- misalign = mem_op & (in_addr mod size ≠ 0).
- Access-path FSM states:
  - IDLE: no accepted request outstanding.
  - WAIT_DATA: address accepted, data pending.
- Request rules:
  - dreq_valid = mem_op & !misalign & state==IDLE.
  - All dreq_* fields are driven from in_* and stay stable because EX/MEM is stalled.
- Transitions:
  - IDLE → WAIT_DATA when dreq_valid & dresp_addr_ok & !dresp_data_ok.
  - WAIT_DATA → IDLE on dresp_data_ok.
  - IDLE stays IDLE when dreq_valid & dresp_addr_ok & dresp_data_ok.
- complete = dresp_data_ok & (state==WAIT_DATA | (dreq_valid & dresp_addr_ok)). dresp_data_ok outside these conditions is ignored.
- stall_out = mem_op & !misalign & !complete.
- Store lanes:
  - k = in_addr[2:0].
  - dreq_strobe = ((1<<size_bytes)-1) << k, truncated to 8 bits.
  - dreq_data = in_store_data << (8*k).
- Load data:
  - raw = dresp_data >> (8*k), truncated to the access size.
  - funct3 0/1/2/3 sign-extend the 8/16/32/64-bit value.
  - funct3 4/5/6 zero-extend the 8/16/32-bit value.
  - funct3 7 is undefined and must not be issued.
- Output register, updated every edge when reset==1:
  - stall_out=1: out_valid←0 and the other out_* fields are don't-care (bubble).
  - Misaligned access: out_valid←1, out_misalign←1, out_reg_write←0, no bus request issued.
  - Load completing: out_wb_value←extended load data.
  - Any other instruction (including a completing store): out_wb_value←in_addr, out_misalign←0, out_valid←in_valid.
  - out_pc, out_rd and out_reg_write always take the corresponding in_* values (except out_reg_write←0 on a misaligned access).
- Reset: state←IDLE and all out_* ←0. The bus shares the same reset, so no response is pending after reset.

## Timing
- Non-memory instruction: 1-cycle latency, never stalls.
- Memory access with addr_ok & data_ok in the first cycle: 1-cycle latency, no stall.
- In general, stall_out is high from the first cycle up to, but excluding, the cycle in which complete fires. EX/MEM and the output register advance at that edge together.
- dreq_valid stays high until addr_ok. Once addr_ok is seen, it deasserts in WAIT_DATA even though EX/MEM still holds the instruction.
- Each accepted request is followed by exactly one data_ok, received in the same or a later cycle. At most one request is outstanding.
- A reset asserted in WAIT_DATA aborts the access; the first cycle after reset is IDLE.

## Test plan
- Non-memory op (in_addr=0x1234, rd=5) with bus idle -> next cycle out_valid=1, out_wb_value=0x1234; stall_out never asserts.
- LB at addr 0x1003 with dresp_data=0x00000000_80000000, addr_ok+data_ok in cycle 0 -> no stall; out_wb_value=0xFFFF_FFFF_FFFF_FF80. The same access as LBU gives 0x80.
- SH at addr 0x1006 with store_data=0xBEEF -> dreq_strobe=0xC0, dreq_data=0xBEEF_0000_0000_0000, dreq_size=1.
- LD at 0x2000 with addr_ok at cycle 2 and data_ok at cycle 5:
  - stall_out is high in cycles 0–4.
  - dreq_valid is high in cycles 0–2 only.
  - The result appears after edge 5.
- LW at 0x2002 -> no dreq_valid; next cycle out_valid=1, out_misalign=1, out_reg_write=0.
- reset=0 while in WAIT_DATA -> state IDLE and all out_* equal 0 after the edge; a new request is accepted normally afterward.
